// File: rtl/gb_stream_loader.sv
// Global-buffer fill engine: accepts a load command, then turns a valid/ready word
// stream into registered write strobes for the selected iact / weight / psum GLB.
module gb_stream_loader #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int LEN_BITWIDTH  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_target,
    input  logic [ADDR_BITWIDTH-1:0] cmd_base,
    input  logic [LEN_BITWIDTH-1:0]  cmd_len,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_BITWIDTH-1:0] s_data,
    output logic                     write_en_iact,
    output logic                     write_en_wght,
    output logic                     write_en_psum,
    output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
    output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
    output logic [ADDR_BITWIDTH-1:0] w_addr_psum,
    output logic [DATA_BITWIDTH-1:0] w_data_iact,
    output logic [DATA_BITWIDTH-1:0] w_data_wght,
    output logic [DATA_BITWIDTH-1:0] w_data_psum,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]              TGT_IACT = 2'd0;
    localparam logic [1:0]              TGT_WGHT = 2'd1;
    localparam logic [1:0]              TGT_PSUM = 2'd2;
    localparam logic [1:0]              TGT_BAD  = 2'd3;
    localparam logic [LEN_BITWIDTH-1:0] LEN_ONE  = 1;

    state_t                     state;
    logic [1:0]                 tgt_q;
    logic [ADDR_BITWIDTH-1:0]   base_q;
    logic [LEN_BITWIDTH-1:0]    len_q;
    logic [LEN_BITWIDTH-1:0]    count_q;
    logic [ADDR_BITWIDTH-1:0]   w_addr_q;
    logic [DATA_BITWIDTH-1:0]   w_data_q;
    logic [ADDR_BITWIDTH-1:0]   beat_addr;

    // Addresses wrap naturally by truncating to ADDR_BITWIDTH bits.
    assign beat_addr = base_q + count_q[ADDR_BITWIDTH-1:0];

    // Handshakes: a transfer happens on a rising edge where both valid and ready are 1.
    // cmd_ready is high only in IDLE (and never during reset); s_ready only in LOAD.
    assign cmd_ready = (state == IDLE) && reset;
    assign s_ready   = (state == LOAD);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign w_addr_iact = w_addr_q;
    assign w_addr_wght = w_addr_q;
    assign w_addr_psum = w_addr_q;
    assign w_data_iact = w_data_q;
    assign w_data_wght = w_data_q;
    assign w_data_psum = w_data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            tgt_q         <= '0;
            base_q        <= '0;
            len_q         <= '0;
            count_q       <= '0;
            write_en_iact <= 1'b0;
            write_en_wght <= 1'b0;
            write_en_psum <= 1'b0;
            w_addr_q      <= '0;
            w_data_q      <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            // Strobes and status pulses last exactly one cycle unless re-armed below.
            write_en_iact <= 1'b0;
            write_en_wght <= 1'b0;
            write_en_psum <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tgt_q   <= cmd_target;
                        base_q  <= cmd_base;
                        len_q   <= cmd_len;
                        count_q <= '0;
                        if (cmd_target == TGT_BAD) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else if (cmd_len == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        write_en_iact <= (tgt_q == TGT_IACT);
                        write_en_wght <= (tgt_q == TGT_WGHT);
                        write_en_psum <= (tgt_q == TGT_PSUM);
                        w_addr_q      <= beat_addr;
                        w_data_q      <= s_data;
                        count_q       <= count_q + LEN_ONE;
                        // Last beat: its strobe and the done pulse appear together.
                        if (count_q == len_q - LEN_ONE) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gb_stream_loader.sv
// Self-checking bench for gb_stream_loader: observed strobes/pulses are logged per cycle
// and compared with an event list built from the command/stream rules.
`timescale 1ns/1ps
module tb_gb_stream_loader;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int LW = 11;
    localparam int EW = 32 + 2 + 2 + AW + DW;
    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_target;
    logic [AW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          write_en_iact, write_en_wght, write_en_psum;
    logic [AW-1:0] w_addr_iact, w_addr_wght, w_addr_psum;
    logic [DW-1:0] w_data_iact, w_data_wght, w_data_psum;
    logic          busy, done, err;
    logic [1:0]    dbg_state;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] cyc          = 0;

    // Event word: {cycle, kind, target, addr, data}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    gb_stream_loader #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .LEN_BITWIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .write_en_iact(write_en_iact), .write_en_wght(write_en_wght), .write_en_psum(write_en_psum),
        .w_addr_iact(w_addr_iact), .w_addr_wght(w_addr_wght), .w_addr_psum(w_addr_psum),
        .w_data_iact(w_data_iact), .w_data_wght(w_data_wght), .w_data_psum(w_data_psum),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Monitor: log every strobe and pulse seen in the cycle following an edge
    always @(negedge clk) begin
        if (write_en_iact === 1'b1) obs_q.push_back({cyc, K_WR, 2'd0, w_addr_iact, w_data_iact});
        if (write_en_wght === 1'b1) obs_q.push_back({cyc, K_WR, 2'd1, w_addr_wght, w_data_wght});
        if (write_en_psum === 1'b1) obs_q.push_back({cyc, K_WR, 2'd2, w_addr_psum, w_data_psum});
        if (done === 1'b1) obs_q.push_back({cyc, K_DONE, 2'd0, {AW{1'b0}}, {DW{1'b0}}});
        if (err === 1'b1)  obs_q.push_back({cyc, K_ERR, 2'd0, {AW{1'b0}}, {DW{1'b0}}});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // Driver + reference model: issue one command, stream its words, and append the
    // expected events (write at the beat's edge, done/err pulses) to exp_q.
    task automatic drive_cmd(input logic [1:0] tgt, input int base, input int len, input int pct,
                             input logic [31:0] pat, input int pat_len, input bit seq_data,
                             input int abort_after);
        int n;
        int k;
        int a;
        bit aborted;
        logic [31:0] acc;
        n = 0;
        k = 0;
        aborted = 1'b0;
        @(negedge clk);
        s_valid    = 1'b0;
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_base   = base[AW-1:0];
        cmd_len    = len[LW-1:0];
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_before_cmd: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (tgt == 2'd3) begin
            exp_q.push_back({acc, K_ERR, 2'd0, {AW{1'b0}}, {DW{1'b0}}});
        end else if (len == 0) begin
            exp_q.push_back({acc, K_DONE, 2'd0, {AW{1'b0}}, {DW{1'b0}}});
        end else begin
            while (n < len && !aborted) begin
                @(negedge clk);
                cmd_valid  = 1'($urandom_range(0, 1));
                cmd_target = 2'($urandom);
                cmd_base   = AW'($urandom);
                cmd_len    = LW'($urandom);
                tests_run++;
                if (s_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL load_handshake: s_ready=%b busy=%b cmd_ready=%b, required 1 1 0",
                             s_ready, busy, cmd_ready);
                end
                if (abort_after >= 0 && n == abort_after) begin
                    reset     = 1'b0;
                    s_valid   = 1'b1;
                    s_data    = DW'($urandom);
                    cmd_valid = 1'b1;
                    @(negedge clk);
                    tests_run++;
                    if (busy !== 1'b0 || cmd_ready !== 1'b0 || write_en_iact !== 1'b0 || done !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL abort_state: busy=%b cmd_ready=%b we_iact=%b done=%b, required 0 0 0 0",
                                 busy, cmd_ready, write_en_iact, done);
                    end
                    @(negedge clk);
                    reset     = 1'b1;
                    s_valid   = 1'b0;
                    cmd_valid = 1'b0;
                    aborted   = 1'b1;
                end else begin
                    if (pat_len > 0) s_valid = pat[k % pat_len];
                    else s_valid = ($urandom_range(0, 99) < pct);
                    k++;
                    s_data = seq_data ? (16'h11 + n[15:0]) : DW'($urandom);
                    @(posedge clk);
                    #1;
                    if (s_valid) begin
                        a = (base + n) % (1 << AW);
                        exp_q.push_back({cyc, K_WR, tgt, a[AW-1:0], s_data});
                        if (n == len - 1) exp_q.push_back({cyc, K_DONE, 2'd0, {AW{1'b0}}, {DW{1'b0}}});
                        n++;
                    end
                end
            end
        end
        if (!aborted) begin
            // Completion cycle: stream and command must both be refused
            @(negedge clk);
            cmd_valid = 1'b0;
            s_valid   = 1'b1;
            s_data    = DW'($urandom);
            tests_run++;
            if (busy !== 1'b1 || s_ready !== 1'b0 || cmd_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_cycle: busy=%b s_ready=%b cmd_ready=%b, required 1 0 0",
                         busy, s_ready, cmd_ready);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        s_valid   = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid  = 1'($urandom);
            cmd_target = 2'($urandom);
            cmd_base   = AW'($urandom);
            cmd_len    = LW'($urandom);
            s_valid    = 1'($urandom);
            s_data     = DW'($urandom);
            @(negedge clk);
            tests_run++;
            if ({write_en_iact, write_en_wght, write_en_psum, done, err, busy, cmd_ready, s_ready} !== 8'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs: we=%b%b%b done=%b err=%b busy=%b cmd_ready=%b s_ready=%b, required all 0",
                         write_en_iact, write_en_wght, write_en_psum, done, err, busy, cmd_ready, s_ready);
            end
        end
        reset     = 1'b1;
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1 || w_addr_iact !== '0 || w_data_psum !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: cmd_ready=%b addr=%0d data=%h, required 1 0 0",
                     cmd_ready, w_addr_iact, w_data_psum);
        end
        obs_q.delete();
    endtask

    task automatic test_incr_iact();
        logic [EW-1:0] got;
        exp_q.delete();
        obs_q.delete();
        drive_cmd(2'd0, 5, 4, 100, 32'h0, 0, 1'b1, -1);
        settle();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL incr_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL incr_event[%0d]: got %h, required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap_wght();
        logic [EW-1:0] got;
        exp_q.delete();
        obs_q.delete();
        drive_cmd(2'd1, 1022, 4, 100, 32'h0, 0, 1'b0, -1);
        settle();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL wrap_event[%0d]: got %h, required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_gaps_psum();
        logic [EW-1:0] got;
        exp_q.delete();
        obs_q.delete();
        drive_cmd(2'd2, 0, 3, 0, 32'h29, 6, 1'b0, -1);
        settle();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL gaps_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL gaps_event[%0d]: got %h, required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_and_illegal();
        logic [EW-1:0] got;
        exp_q.delete();
        obs_q.delete();
        drive_cmd(2'd0, 17, 0, 100, 32'h0, 0, 1'b0, -1);
        drive_cmd(2'd3, 40, 8, 100, 32'h0, 0, 1'b0, -1);
        settle();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL zero_illegal_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL zero_illegal_event[%0d]: got %h, required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [EW-1:0] got;
        exp_q.delete();
        obs_q.delete();
        drive_cmd(2'd0, 0, 8, 100, 32'h0, 0, 1'b0, 2);
        drive_cmd(2'd0, 100, 1, 100, 32'h0, 0, 1'b0, -1);
        settle();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL abort_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL abort_event[%0d]: got %h, required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] got;
        int len;
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < 14; c++) begin
            len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
            drive_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 1023)), len,
                      int'($urandom_range(30, 100)), 32'h0, 0, 1'b0, -1);
        end
        // Long command: wraps past the top of the buffer and overwrites earlier words
        drive_cmd(2'd1, 1020, 1030, 100, 32'h0, 0, 1'b0, -1);
        settle();
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_event[%0d]: got %h, required %h", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = 2'd0;
        cmd_base   = '0;
        cmd_len    = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        test_reset();
        test_incr_iact();
        test_wrap_wght();
        test_gaps_psum();
        test_zero_and_illegal();
        test_reset_mid_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
